// File: rtl/cart_bank_mapper.sv
// Cartridge ROM bank mapper: translates CPU word addresses through a bank table
// and bridges the CPU toggle req/ack handshake onto the DDRAM read port.
module cart_bank_mapper #(
    parameter int N_BANKS = 8,
    parameter int BANK_W  = 6,
    parameter int ADDR_W  = 21,
    parameter int IDX_W   = $clog2(N_BANKS),
    parameter int WIN_W   = ADDR_W - IDX_W
) (
    input  logic                    MCLK,
    input  logic                    RESET_N,
    input  logic                    LOADING,
    input  logic                    MAPPER_WE,
    input  logic [IDX_W-1:0]        MAPPER_A,
    input  logic [BANK_W-1:0]       MAPPER_D,
    input  logic [BANK_W-1:0]       ROM_MASK,
    input  logic [ADDR_W-1:0]       CPU_ADDR,
    input  logic                    CPU_REQ,
    output logic                    CPU_ACK,
    output logic [15:0]             CPU_DATA,
    output logic [BANK_W+WIN_W-1:0] MEM_ADDR,
    output logic                    MEM_REQ,
    input  logic                    MEM_ACK,
    input  logic [15:0]             MEM_DATA,
    output logic                    SRAM_EN,
    output logic                    SRAM_WP,
    output logic                    MAP_ACTIVE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t state;
    state_t next_state;

    logic [BANK_W-1:0] bank_map [N_BANKS];
    logic              loading_q;
    logic              load_rise;
    logic [IDX_W-1:0]  idx;
    logic [WIN_W-1:0]  off;
    logic [BANK_W-1:0] bank_sel;
    logic              pending;
    logic              mem_done;

    assign load_rise = LOADING & ~loading_q;
    assign idx       = CPU_ADDR[ADDR_W-1:WIN_W];
    assign off       = CPU_ADDR[WIN_W-1:0];
    assign pending   = (CPU_REQ != CPU_ACK) && !LOADING;
    assign mem_done  = (MEM_ACK == MEM_REQ);

    // Register file; a download start restores defaults and overrides a same-cycle write.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < N_BANKS; i++) begin
                bank_map[i] <= BANK_W'(i);
            end
            SRAM_EN    <= 1'b0;
            SRAM_WP    <= 1'b0;
            MAP_ACTIVE <= 1'b0;
            loading_q  <= 1'b0;
        end else begin
            loading_q <= LOADING;
            if (load_rise) begin
                for (int i = 0; i < N_BANKS; i++) begin
                    bank_map[i] <= BANK_W'(i);
                end
                SRAM_EN    <= 1'b0;
                SRAM_WP    <= 1'b0;
                MAP_ACTIVE <= 1'b0;
            end else if (MAPPER_WE) begin
                if (MAPPER_A == '0) begin
                    SRAM_EN <= MAPPER_D[0];
                    SRAM_WP <= MAPPER_D[1];
                end else begin
                    bank_map[MAPPER_A] <= MAPPER_D;
                    MAP_ACTIVE         <= 1'b1;
                end
            end
        end
    end

    // Until a slot is written the mapper is transparent and the ROM mask is bypassed.
    always_comb begin
        bank_sel = BANK_W'(idx);
        if (MAP_ACTIVE) begin
            bank_sel = bank_map[idx] & ROM_MASK;
        end
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (pending) next_state = S_ISSUE;
            S_ISSUE: next_state = S_WAIT;
            S_WAIT:  if (mem_done) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            MEM_ADDR <= '0;
            MEM_REQ  <= 1'b0;
            CPU_ACK  <= 1'b0;
            CPU_DATA <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pending) begin
                        MEM_ADDR <= {bank_sel, off};
                    end
                end
                S_ISSUE: begin
                    MEM_REQ <= ~MEM_REQ;
                end
                S_WAIT: begin
                    if (mem_done) begin
                        CPU_DATA <= MEM_DATA;
                        CPU_ACK  <= ~CPU_ACK;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
